// File: rtl/rf_2r1w.sv
// Parametrised 2-read/1-write register file with registered reads, read-valid flags and
// out-of-range error reporting. Define RF_BYPASS_EN for write-first same-address reads.
module rf_2r1w #(
    parameter int DATA_W    = 8,
    parameter int DEPTH     = 8,
    parameter int ADDR_W    = $clog2(DEPTH),
    parameter int ERR_CNT_W = 4
) (
    input  logic                 clk,
    input  logic                 resetn,
    input  logic                 wr,
    input  logic [ADDR_W-1:0]    waddr,
    input  logic [DATA_W-1:0]    din,
    input  logic                 rd0,
    input  logic [ADDR_W-1:0]    raddr0,
    output logic [DATA_W-1:0]    dout0,
    output logic                 rvalid0,
    input  logic                 rd1,
    input  logic [ADDR_W-1:0]    raddr1,
    output logic [DATA_W-1:0]    dout1,
    output logic                 rvalid1,
    output logic                 error,
    output logic [ERR_CNT_W-1:0] err_cnt
);

    // One extra bit so the bound compares cleanly even when DEPTH is a power of two.
    localparam logic [ADDR_W:0] DEPTH_C = (ADDR_W + 1)'(DEPTH);

    logic [DATA_W-1:0]    mem_q [DEPTH];
    logic [DATA_W-1:0]    mem_d [DEPTH];
    logic [DATA_W-1:0]    dout0_q, dout0_d;
    logic [DATA_W-1:0]    dout1_q, dout1_d;
    logic                 rvalid0_q, rvalid0_d;
    logic                 rvalid1_q, rvalid1_d;
    logic                 error_q, error_d;
    logic [ERR_CNT_W-1:0] err_cnt_q, err_cnt_d;

    logic w_in, r0_in, r1_in;
    logic w_ok, r0_ok, r1_ok;
    logic byp0, byp1;
    logic oor;

    always_comb begin
        w_in  = {1'b0, waddr}  < DEPTH_C;
        r0_in = {1'b0, raddr0} < DEPTH_C;
        r1_in = {1'b0, raddr1} < DEPTH_C;
        w_ok  = wr  && w_in;
        r0_ok = rd0 && r0_in;
        r1_ok = rd1 && r1_in;
        oor   = (wr && !w_in) || (rd0 && !r0_in) || (rd1 && !r1_in);
    end

`ifdef RF_BYPASS_EN
    assign byp0 = w_ok && (waddr == raddr0);
    assign byp1 = w_ok && (waddr == raddr1);
`else
    assign byp0 = 1'b0;
    assign byp1 = 1'b0;
`endif

    // NOTE: every variable gets a default at the top of always_comb so no path leaves it unassigned (no latch).
    always_comb begin
        mem_d     = mem_q;
        dout0_d   = '0;
        rvalid0_d = 1'b0;
        dout1_d   = '0;
        rvalid1_d = 1'b0;
        error_d   = oor;
        err_cnt_d = err_cnt_q;

        if (w_ok) begin
            mem_d[waddr] = din;
        end
        if (r0_ok) begin
            dout0_d   = byp0 ? din : mem_q[raddr0];
            rvalid0_d = 1'b1;
        end
        if (r1_ok) begin
            dout1_d   = byp1 ? din : mem_q[raddr1];
            rvalid1_d = 1'b1;
        end
        if (oor && (err_cnt_q != '1)) begin
            err_cnt_d = err_cnt_q + 1'b1;
        end
    end

    // NOTE: the storage array is reset too, because a cleared file is part of the visible contract.
    // NOTE: sequential state uses non-blocking assignments so all flops sample pre-edge values.
    always_ff @(posedge clk) begin
        if (!resetn) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
            dout0_q   <= '0;
            dout1_q   <= '0;
            rvalid0_q <= 1'b0;
            rvalid1_q <= 1'b0;
            error_q   <= 1'b0;
            err_cnt_q <= '0;
        end else begin
            mem_q     <= mem_d;
            dout0_q   <= dout0_d;
            dout1_q   <= dout1_d;
            rvalid0_q <= rvalid0_d;
            rvalid1_q <= rvalid1_d;
            error_q   <= error_d;
            err_cnt_q <= err_cnt_d;
        end
    end

    assign dout0   = dout0_q;
    assign dout1   = dout1_q;
    assign rvalid0 = rvalid0_q;
    assign rvalid1 = rvalid1_q;
    assign error   = error_q;
    assign err_cnt = err_cnt_q;

endmodule

// File: tb/tb_rf_2r1w.sv
// Self-checking bench for rf_2r1w (DEPTH=6, ERR_CNT_W=2) against an array-based reference model.
module tb_rf_2r1w;

    localparam int DATA_W    = 8;
    localparam int DEPTH     = 6;
    localparam int ADDR_W    = 3;
    localparam int ERR_CNT_W = 2;
    localparam int CNT_MAX   = 3;

    logic              clk = 1'b0;
    logic              resetn;
    logic              wr;
    logic [ADDR_W-1:0] waddr;
    logic [DATA_W-1:0] din;
    logic              rd0, rd1;
    logic [ADDR_W-1:0] raddr0, raddr1;
    logic [DATA_W-1:0] dout0, dout1;
    logic              rvalid0, rvalid1;
    logic              error;
    logic [ERR_CNT_W-1:0] err_cnt;

    int n_tests = 0;
    int n_fail  = 0;

    int model [8];
    int model_cnt;

    rf_2r1w #(
        .DATA_W   (DATA_W),
        .DEPTH    (DEPTH),
        .ERR_CNT_W(ERR_CNT_W)
    ) dut (
        .clk    (clk),
        .resetn (resetn),
        .wr     (wr),
        .waddr  (waddr),
        .din    (din),
        .rd0    (rd0),
        .raddr0 (raddr0),
        .dout0  (dout0),
        .rvalid0(rvalid0),
        .rd1    (rd1),
        .raddr1 (raddr1),
        .dout1  (dout1),
        .rvalid1(rvalid1),
        .error  (error),
        .err_cnt(err_cnt)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input int got, input int exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    function automatic int expect_read(input logic r, input int a, input logic w, input int wa,
                                       input int d);
        if (!r || a >= DEPTH) return 0;
`ifdef RF_BYPASS_EN
        if (w && wa == a) return d;
`endif
        return model[a];
    endfunction

    // One functional cycle: drive, predict, clock, compare.
    task automatic cycle(input logic w, input int wa, input int d,
                         input logic r0, input int a0, input logic r1, input int a1);
        int  e_d0, e_d1;
        bit  e_v0, e_v1, e_err;
        resetn = 1'b1;
        wr = w; waddr = ADDR_W'(wa); din = DATA_W'(d);
        rd0 = r0; raddr0 = ADDR_W'(a0);
        rd1 = r1; raddr1 = ADDR_W'(a1);
        e_d0  = expect_read(r0, a0, w, wa, d);
        e_d1  = expect_read(r1, a1, w, wa, d);
        e_v0  = r0 && a0 < DEPTH;
        e_v1  = r1 && a1 < DEPTH;
        e_err = (w && wa >= DEPTH) || (r0 && a0 >= DEPTH) || (r1 && a1 >= DEPTH);
        if (w && wa < DEPTH) model[wa] = d;
        if (e_err && model_cnt < CNT_MAX) model_cnt++;
        @(posedge clk);
        #1;
        check("dout0",   int'(dout0),   e_d0);
        check("rvalid0", int'(rvalid0), int'(e_v0));
        check("dout1",   int'(dout1),   e_d1);
        check("rvalid1", int'(rvalid1), int'(e_v1));
        check("error",   int'(error),   int'(e_err));
        check("err_cnt", int'(err_cnt), model_cnt);
    endtask

    task automatic reset_cycle(input logic w, input int wa, input int d, input logic r0);
        resetn = 1'b0;
        wr = w; waddr = ADDR_W'(wa); din = DATA_W'(d);
        rd0 = r0; raddr0 = ADDR_W'(wa);
        rd1 = r0; raddr1 = ADDR_W'(wa);
        for (int i = 0; i < 8; i++) model[i] = 0;
        model_cnt = 0;
        @(posedge clk);
        #1;
        check("rst_dout0",   int'(dout0),   0);
        check("rst_rvalid0", int'(rvalid0), 0);
        check("rst_dout1",   int'(dout1),   0);
        check("rst_rvalid1", int'(rvalid1), 0);
        check("rst_error",   int'(error),   0);
        check("rst_err_cnt", int'(err_cnt), 0);
    endtask

    initial begin
        resetn = 1'b0;
        wr = 1'b0; waddr = '0; din = '0;
        rd0 = 1'b0; raddr0 = '0; rd1 = 1'b0; raddr1 = '0;

        // Reset while a write and a read are presented: both are discarded.
        reset_cycle(1'b1, 1, 'h77, 1'b1);
        cycle(0, 0, 0, 1, 1, 1, 1);

        // Reads after reset return zero with valid set.
        cycle(0, 0, 0, 1, 3, 1, 5);

        // Two writes, then dual read.
        cycle(1, 2, 'hA5, 0, 0, 0, 0);
        cycle(1, 5, 'h3C, 0, 0, 0, 0);
        cycle(0, 0, 0, 1, 2, 1, 5);

        // Same-cycle write and read of the same address; both ports hit it.
        cycle(1, 4, 'h11, 0, 0, 0, 0);
        cycle(1, 4, 'h22, 1, 4, 1, 4);
        cycle(0, 0, 0, 1, 4, 0, 0);

        // Out-of-range write plus out-of-range read; then a single pulse.
        cycle(1, 6, 'hFF, 0, 0, 1, 7);
        cycle(0, 0, 0, 0, 0, 0, 0);
        for (int i = 0; i < DEPTH; i += 2) cycle(0, 0, 0, 1, i, 1, i + 1);

        // Counter saturation from reset, then reset clears it.
        reset_cycle(1'b0, 0, 0, 1'b0);
        for (int i = 0; i < 5; i++) cycle(0, 0, 0, 1, 6 + (i % 2), 0, 0);
        reset_cycle(1'b0, 0, 0, 1'b0);

        // Randomised traffic across in-range and out-of-range addresses.
        for (int i = 0; i < 400; i++) begin
            if ($urandom_range(0, 99) < 2) begin
                reset_cycle(1'($urandom_range(0, 1)), $urandom_range(0, 5),
                            $urandom_range(0, 255), 1'($urandom_range(0, 1)));
            end else begin
                cycle(1'($urandom_range(0, 1)), $urandom_range(0, 7), $urandom_range(0, 255),
                      1'($urandom_range(0, 1)), $urandom_range(0, 7),
                      1'($urandom_range(0, 1)), $urandom_range(0, 7));
            end
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/rf_2r1w.md
Name: rf_2r1w

Overview:
- Parametrised register file: one write port, two independent read ports.
- Generalises the 8x8 single-port flip-flop array. Write and reads may now happen in the same cycle and are no longer an error.
- Error reporting moves to out-of-range addressing. Adds per-port read-valid flags and a saturating error counter.
- Used as the scratch/state store for small datapath controllers.

Parameters:
- DATA_W, 8, width of each entry in bits (>=1)
- DEPTH, 8, number of entries (>=2; need not be a power of two)
- ADDR_W, $clog2(DEPTH), address port width (derived; never overridden)
- ERR_CNT_W, 4, width of the saturating error counter

Ports:
- clk  in  1  clock; all logic on rising edge
- resetn  in  1  synchronous, active-low reset
- wr  in  1  write enable
- waddr  in  ADDR_W  write address
- din  in  DATA_W  write data
- rd0  in  1  read enable, port 0
- raddr0  in  ADDR_W  read address, port 0
- dout0  out  DATA_W  read data, port 0 (registered)
- rvalid0  out  1  dout0 holds valid read data
- rd1  in  1  read enable, port 1
- raddr1  in  ADDR_W  read address, port 1
- dout1  out  DATA_W  read data, port 1 (registered)
- rvalid1  out  1  dout1 holds valid read data
- error  out  1  one-cycle pulse: an out-of-range access occurred in the previous cycle
- err_cnt  out  ERR_CNT_W  saturating count of cycles in which error was raised

Behaviour:
- Reset (resetn=0 at a rising edge):
  - All DEPTH entries cleared to 0.
  - dout0, dout1, rvalid0, rvalid1, error and err_cnt all cleared to 0.
  - Reset overrides every in-flight access. A write presented in the reset cycle is discarded.
- Write:
  - wr=1 and waddr<DEPTH: entry[waddr] <= din at the edge.
  - wr=1 and waddr>=DEPTH: no entry changes; counts as an out-of-range access.
- Read, port k (k=0,1), 1-cycle latency:
  - rdk=1 and raddrk<DEPTH: next cycle doutk = entry[raddrk], rvalidk=1.
  - rdk=1 and raddrk>=DEPTH: next cycle doutk=0, rvalidk=0; counts as an out-of-range access.
  - rdk=0: next cycle doutk=0, rvalidk=0. Outputs do not hold the previous read.
- Simultaneous events:
  - wr together with rd0 and/or rd1 is legal; all three are serviced in the same cycle.
  - Read and write to the same address in the same cycle: read data is governed by RF_BYPASS_EN (see Optional Feature).
  - Both read ports on the same address return identical data.
- Error:
  - error <= 1 for exactly one cycle after any cycle with at least one out-of-range access. Multiple offending ports in one cycle still give a single pulse.
  - err_cnt increments by 1 per such cycle and saturates at 2^ERR_CNT_W-1. It clears only on reset.
- Power-of-two DEPTH: out-of-range addresses cannot occur, so error and err_cnt stay 0. The logic is still present.

Optional Feature:
- Macro: RF_BYPASS_EN.
- Defined (write-first): a same-cycle read of the address being validly written returns din. doutk = din next cycle, rvalidk=1.
- Not defined (read-first): such a read returns the entry's old contents. The new value is visible from the following cycle's read onward.
- The feature has no effect on an out-of-range write.

Test Plan:
- Reset, then rd0=1 raddr0=3 and rd1=1 raddr1=7 -> next cycle dout0=0, dout1=0, rvalid0=rvalid1=1, error=0, err_cnt=0.
- Write 0xA5 to addr 2 and 0x3C to addr 5, then rd0 addr 2 and rd1 addr 5 in the same cycle -> next cycle dout0=0xA5, dout1=0x3C, both rvalid=1.
- Entry 4 holds 0x11; in one cycle wr=1 waddr=4 din=0x22 and rd0=1 raddr0=4:
  - Without RF_BYPASS_EN -> dout0=0x11, then a read the cycle after returns 0x22.
  - With RF_BYPASS_EN -> dout0=0x22.
- DEPTH=6: wr=1 waddr=6 din=0xFF plus rd1=1 raddr1=7 in one cycle -> next cycle error=1 (single pulse), err_cnt=1, dout1=0, rvalid1=0; readback of entries 0..5 unchanged.
- ERR_CNT_W=2, DEPTH=6: 5 consecutive out-of-range cycles -> err_cnt goes 1,2,3,3,3; error high 5 cycles; then resetn=0 for one cycle -> err_cnt=0, error=0.
- Reset asserted while wr=1 waddr=1 din=0x77 and rd0=1 -> after reset entry 1 reads 0, dout0=0, rvalid0=0.
